// File: rtl/ifetch_pkg.sv
// Shared CPU definitions: instruction opcode fields and the fetch-fault substitute.
package ifetch_pkg;

  // Low two bits of an instruction halfword select the compressed quadrant.
  typedef enum logic [1:0] {
    OpcC0   = 2'b00,
    OpcC1   = 2'b01,
    OpcC2   = 2'b10,
    OpcFull = 2'b11
  } opc_quadrant_e;

  // Major opcodes used by the decoder (bits [6:2] of a 32-bit instruction).
  localparam logic [4:0] OpLoad   = 5'b00000;
  localparam logic [4:0] OpOpImm  = 5'b00100;
  localparam logic [4:0] OpStore  = 5'b01000;
  localparam logic [4:0] OpOp     = 5'b01100;
  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpJal    = 5'b11011;
  localparam logic [4:0] OpSystem = 5'b11100;

  // All-zero halfword is the defined illegal instruction; the decoder traps on it,
  // so a faulted fetch is turned into this value rather than carrying a side flag.
  localparam logic [15:0] FaultIns = 16'h0000;

  function automatic opc_quadrant_e ins_quadrant(input logic [15:0] ins);
    return opc_quadrant_e'(ins[1:0]);
  endfunction

  function automatic logic is_compressed(input logic [15:0] ins);
    return ins[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction queue: DEPTH-entry circular buffer with flush, simultaneous push/pop.
module ifetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 48
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Guard against popping empty or pushing full so the queue can never corrupt itself.
  always_comb begin
    do_pop  = pop_i & (cnt_q != '0);
    do_push = push_i & ((cnt_q != Full) | do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        wptr_d = wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding halfword request, queue to decode, redirect/discard.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned   RV       = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [RV-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          mem_req,
  output logic [RV-2:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_fault,
  input  logic          accept,
  input  logic          redirect,
  input  logic [RV-1:0] redirect_pc,
  output logic [15:0]   ins,
  output logic [RV-1:0] ins_pc,
  output logic          idone
);

  localparam int unsigned   CntW    = $clog2(DEPTH) + 1;
  localparam int unsigned   EntryW  = 16 + RV;
  localparam logic [RV-1:0] PcMask  = ~RV'(1);
  localparam logic [RV-1:0] ResetPc = RESET_PC & PcMask;

  logic [RV-1:0]     pc_q, pc_d;
  logic [RV-2:0]     addr_q, addr_d;
  logic              req_q, req_d;
  logic              discard_q, discard_d;

  logic              ack;
  logic              push;
  logic              empty;
  logic [CntW-1:0]   count;
  logic [CntW-1:0]   count_next;
  logic [EntryW-1:0] push_data;
  logic [EntryW-1:0] head;

  // An ack only counts against a request we actually have outstanding; stray acks
  // (e.g. for a request abandoned by reset) are ignored.
  assign ack  = req_q & mem_ack;
  assign push = ack & ~discard_q & ~redirect;

  assign push_data = {(mem_fault ? FaultIns : mem_rdata), pc_q};

  assign idone = ~empty & accept & ~redirect;

  // Queue occupancy as it will be after this cycle's flush/push/pop.
  always_comb begin
    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else begin
      count_next = count + CntW'(push) - CntW'(idone);
    end
  end

  // Fetch PC, discard tracking and request issue.
  always_comb begin
    pc_d      = pc_q;
    addr_d    = addr_q;
    req_d     = req_q;
    discard_d = discard_q;

    if (push) begin
      pc_d = pc_q + RV'(2);
    end
    if (redirect) begin
      pc_d = redirect_pc & PcMask;
    end

    // Any taken ack retires the outstanding request, discarded or not.
    if (ack) begin
      discard_d = 1'b0;
    end
    // Request still in flight across a redirect: its data belongs to the old stream.
    if (redirect && req_q && !mem_ack) begin
      discard_d = 1'b1;
    end

    // A new request may only start once the bus is free. Issuing against the
    // post-cycle count keeps room for the single entry the request will return.
    if (!req_q || ack) begin
      req_d  = (count_next < CntW'(DEPTH));
      addr_d = pc_d[RV-1:1];
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= ResetPc;
      addr_q    <= '0;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      discard_q <= discard_d;
    end
  end

  assign mem_req  = req_q;
  assign mem_addr = addr_q;

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (redirect),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (idone),
    .rdata_o (head),
    .empty_o (empty),
    .count_o (count)
  );

  assign ins    = head[EntryW-1 -: 16];
  assign ins_pc = head[RV-1:0];

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus a randomized stream check.
module tb_ifetch;

  localparam int unsigned RV       = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  typedef struct packed {
    logic [15:0] ins;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [30:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_fault;
  logic        accept;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] ins;
  logic [31:0] ins_pc;
  logic        idone;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifetch #(
    .RV       (RV),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_fault   (mem_fault),
    .accept      (accept),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .idone       (idone)
  );

  // Memory image: a fixed scramble of the halfword address.
  function automatic logic [15:0] word(input logic [30:0] a);
    logic [15:0] t;
    t = a[15:0];
    return (t ^ 16'h3C5A) + {t[7:0], t[15:8]};
  endfunction

  task automatic idle_inputs();
    mem_ack     = 1'b0;
    mem_rdata   = 16'h0;
    mem_fault   = 1'b0;
    accept      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
  endtask

  // Leaves the caller at the negedge opening the first cycle after reset release.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    accept = 1'b1;
    reset  = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
    checks++; if (idone !== 1'b0) begin errors++; $display("FAIL reset_idone: got %b want 0", idone); end
    checks++; if (ins !== 16'h0) begin errors++; $display("FAIL reset_ins: got %h want 0000", ins); end
    checks++; if (ins_pc !== 32'h0) begin errors++; $display("FAIL reset_ins_pc: got %h want 0", ins_pc); end
    @(negedge clk);
    reset   = 1'b0;
    mem_ack = 1'b1;  // must be ignored: nothing is outstanding yet
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_first_cycle_req: got %b want 0", mem_req); end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_req_rise: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 31'h80) begin errors++; $display("FAIL reset_addr: got %h want 80", mem_addr); end
    checks++; if (idone !== 1'b0) begin errors++; $display("FAIL reset_stray_ack: got idone %b want 0", idone); end
    idle_inputs();
  endtask

  task automatic test_stream();
    logic [30:0] exp_addr;
    logic [31:0] exp_pc;
    int          n_idone;
    do_reset();
    accept   = 1'b1;
    exp_addr = 31'h80;
    exp_pc   = RESET_PC;
    n_idone  = 0;
    for (int c = 0; c < 12; c++) begin
      mem_ack = mem_req;
      if (mem_req) begin
        checks++;
        if (mem_addr !== exp_addr) begin
          errors++; $display("FAIL stream_addr: got %h want %h", mem_addr, exp_addr);
        end
        mem_rdata = word(exp_addr);
        exp_addr  = exp_addr + 31'd1;
      end
      #1;
      if (idone) begin
        checks++;
        if ({ins_pc, ins} !== {exp_pc, word(exp_pc[31:1])}) begin
          errors++; $display("FAIL stream_ins: got %h/%h want %h/%h", ins_pc, ins, exp_pc, word(exp_pc[31:1]));
        end
        exp_pc = exp_pc + 32'd2;
        n_idone++;
      end
      @(negedge clk);
    end
    checks++; if (n_idone != 10) begin errors++; $display("FAIL stream_count: got %0d want 10", n_idone); end
    idle_inputs();
  endtask

  task automatic test_fill();
    int n_ack;
    do_reset();
    n_ack = 0;
    for (int c = 0; c < 12; c++) begin
      mem_ack = mem_req;
      if (mem_req) begin
        n_ack++;
        mem_rdata = word(mem_addr);
      end
      #1;
      checks++; if (idone !== 1'b0) begin errors++; $display("FAIL fill_idone: got %b want 0", idone); end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    accept  = 1'b1;
    #1;
    checks++; if (n_ack != DEPTH) begin errors++; $display("FAIL fill_acks: got %0d want %0d", n_ack, DEPTH); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_req_full: got %b want 0", mem_req); end
    checks++; if (idone !== 1'b1) begin errors++; $display("FAIL fill_pop: got %b want 1", idone); end
    checks++;
    if ({ins_pc, ins} !== {RESET_PC, word(31'h80)}) begin
      errors++; $display("FAIL fill_head: got %h/%h want %h/%h", ins_pc, ins, RESET_PC, word(31'h80));
    end
    @(negedge clk);
    accept = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fill_refetch: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 31'h84) begin errors++; $display("FAIL fill_refetch_addr: got %h want 84", mem_addr); end
    mem_ack   = 1'b1;
    mem_rdata = word(31'h84);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_refull: got %b want 0", mem_req); end
    idle_inputs();
  endtask

  task automatic test_redirect_pending();
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 31'h100}) begin
      errors++; $display("FAIL pend_first_req: got %b/%h want 1/100", mem_req, mem_addr);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    redirect = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 31'h100}) begin
        errors++; $display("FAIL pend_hold: got %b/%h want 1/100", mem_req, mem_addr);
      end
      @(negedge clk);
    end
    mem_ack   = 1'b1;
    mem_rdata = 16'h1234;
    accept    = 1'b1;
    #1;
    checks++; if (idone !== 1'b0) begin errors++; $display("FAIL pend_stale_idone: got %b want 0", idone); end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++; if (idone !== 1'b0) begin errors++; $display("FAIL pend_dropped: got %b ins %h want idone 0", idone, ins); end
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 31'h200}) begin
      errors++; $display("FAIL pend_restart: got %b/%h want 1/200", mem_req, mem_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({idone, ins_pc, ins} !== {1'b1, 32'h400, 16'hBEEF}) begin
      errors++; $display("FAIL pend_first_ins: got %b/%h/%h want 1/400/beef", idone, ins_pc, ins);
    end
    idle_inputs();
  endtask

  task automatic test_redirect_ack();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      mem_ack = mem_req;
      mem_rdata = word(mem_addr);
      @(negedge clk);
    end
    // Two entries queued, third request (PC 0x104) outstanding.
    accept      = 1'b1;
    mem_ack     = 1'b1;
    mem_rdata   = 16'h5555;
    redirect    = 1'b1;
    redirect_pc = 32'h601;
    #1;
    checks++; if (idone !== 1'b0) begin errors++; $display("FAIL rda_idone: got %b want 0", idone); end
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 31'h82}) begin
      errors++; $display("FAIL rda_pending: got %b/%h want 1/82", mem_req, mem_addr);
    end
    @(negedge clk);
    mem_ack  = 1'b0;
    redirect = 1'b0;
    #1;
    checks++;
    if ({idone, ins, ins_pc} !== {1'b0, 16'h0, 32'h0}) begin
      errors++; $display("FAIL rda_flushed: got %b/%h/%h want 0/0000/0", idone, ins, ins_pc);
    end
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 31'h300}) begin
      errors++; $display("FAIL rda_restart: got %b/%h want 1/300", mem_req, mem_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = word(31'h300);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({idone, ins_pc, ins} !== {1'b1, 32'h600, word(31'h300)}) begin
      errors++; $display("FAIL rda_first_ins: got %b/%h/%h want 1/600/%h", idone, ins_pc, ins, word(31'h300));
    end
    idle_inputs();
  endtask

  task automatic test_fault();
    do_reset();
    accept = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_fault = 1'b1;
    mem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_fault = 1'b0;
    #1;
    checks++;
    if ({idone, ins, ins_pc} !== {1'b1, 16'h0000, RESET_PC}) begin
      errors++; $display("FAIL fault_ins: got %b/%h/%h want 1/0000/%h", idone, ins, ins_pc, RESET_PC);
    end
    checks++; if (mem_addr !== 31'h81) begin errors++; $display("FAIL fault_advance: got %h want 81", mem_addr); end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      mem_ack = mem_req;
      mem_rdata = word(mem_addr);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    accept  = 1'b1;
    @(negedge clk);
    accept = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_pending: got %b want 1", mem_req); end
    accept = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, idone, ins, ins_pc} !== {2'b00, 16'h0, 32'h0}) begin
      errors++; $display("FAIL mid_async: got %b/%b/%h/%h want 0/0/0000/0", mem_req, idone, ins, ins_pc);
    end
    @(negedge clk);
    reset   = 1'b0;
    mem_ack = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_first_cycle: got %b want 0", mem_req); end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr, idone} !== {1'b1, 31'h80, 1'b0}) begin
      errors++; $display("FAIL mid_restart: got %b/%h/%b want 1/80/0", mem_req, mem_addr, idone);
    end
    idle_inputs();
  endtask

  // Reference: the decode stream after any redirect is the sequential halfwords from the
  // target; a request in flight at a redirect is stale; decode sees at most DEPTH buffered.
  task automatic test_random();
    ent_t        q[$];
    ent_t        e;
    logic [31:0] fpc;
    logic        stale, hold, exp_idone, ack_t;
    logic [30:0] haddr;
    int          n_pop;
    do_reset();
    fpc   = RESET_PC;
    stale = 1'b0;
    hold  = 1'b0;
    haddr = '0;
    n_pop = 0;
    for (int c = 0; c < 3000; c++) begin
      accept      = ($urandom_range(9) < 7);
      redirect    = ($urandom_range(24) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      mem_ack     = mem_req & ($urandom_range(1) == 1);
      mem_rdata   = 16'($urandom);
      mem_fault   = ($urandom_range(7) == 0);
      #1;
      if (hold) begin
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, haddr}) begin
          errors++; $display("FAIL rnd_stable: got %b/%h want 1/%h", mem_req, mem_addr, haddr);
        end
      end
      if (c > 0) begin
        checks++;
        if (mem_req !== (q.size() < DEPTH)) begin
          errors++; $display("FAIL rnd_req: got %b want %b (queued %0d)", mem_req, q.size() < DEPTH, q.size());
        end
      end
      if (mem_req && !stale) begin
        checks++;
        if (mem_addr !== fpc[31:1]) begin
          errors++; $display("FAIL rnd_addr: got %h want %h", mem_addr, fpc[31:1]);
        end
      end
      exp_idone = (q.size() != 0) && accept && !redirect;
      checks++;
      if (idone !== exp_idone) begin
        errors++; $display("FAIL rnd_idone: got %b want %b", idone, exp_idone);
      end
      if (q.size() == 0) begin
        checks++;
        if ({ins, ins_pc} !== 48'h0) begin
          errors++; $display("FAIL rnd_empty: got %h/%h want 0000/0", ins, ins_pc);
        end
      end else if (exp_idone) begin
        e = q.pop_front();
        n_pop++;
        checks++;
        if ({ins, ins_pc} !== {e.ins, e.pc}) begin
          errors++; $display("FAIL rnd_ins: got %h/%h want %h/%h", ins, ins_pc, e.ins, e.pc);
        end
      end
      ack_t = mem_req && mem_ack;
      if (redirect) begin
        q.delete();
        if (ack_t) stale = 1'b0;
        else if (mem_req) stale = 1'b1;
        fpc = redirect_pc & ~32'h1;
      end else if (ack_t) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          e.ins = mem_fault ? 16'h0000 : mem_rdata;
          e.pc  = fpc;
          q.push_back(e);
          fpc = fpc + 32'd2;
        end
      end
      hold  = mem_req && !mem_ack;
      haddr = mem_addr;
      @(negedge clk);
    end
    checks++; if (n_pop < 300) begin errors++; $display("FAIL rnd_progress: got %0d pops want >= 300", n_pop); end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_stream();
    test_fill();
    test_redirect_pending();
    test_redirect_ack();
    test_fault();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RV, default 32, meaning register/PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning fetch address after reset (bit 0 ignored).
REQ-004 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port mem_req  output  1  memory fetch request, held until acknowledged.
REQ-007 SHALL have port mem_addr  output  RV-1  halfword address (PC[RV-1:1]) of the request.
REQ-008 SHALL have port mem_ack  input  1  request completed this cycle; mem_rdata/mem_fault valid.
REQ-009 SHALL have port mem_rdata  input  16  fetched instruction halfword.
REQ-010 SHALL have port mem_fault  input  1  fetch fault, qualified by mem_ack.
REQ-011 SHALL have port accept  input  1  decode stage can take an instruction this cycle.
REQ-012 SHALL have port redirect  input  1  branch/jump/trap taken; flush and restart.
REQ-013 SHALL have port redirect_pc  input  RV  new fetch PC, qualified by redirect.
REQ-014 SHALL have port ins  output  16  instruction at queue head, to decoder ins.
REQ-015 SHALL have port ins_pc  output  RV  PC of ins, bit 0 zero.
REQ-016 SHALL have port idone  output  1  ins valid and consumed this cycle (decoder latches on it).

Function
REQ-017 SHALL keep at most one outstanding memory request; mem_addr and mem_req stable from assertion until the cycle mem_ack is sampled high.
REQ-018 SHALL assert mem_req whenever no request is outstanding and (queue count + 0) < DEPTH, or a discard-pending restart exists; fetch PC advances by 2 on each accepted (non-discarded) ack.
REQ-019 SHALL push {mem_rdata, fetch PC} into the queue on mem_ack unless discard flag set; mem_fault SHALL push 16'h0000 (decodes as trap) instead of mem_rdata.
REQ-020 SHALL make a pushed entry visible on ins/ins_pc in the cycle after mem_ack (1-cycle ack-to-idone latency minimum).
REQ-021 SHALL drive idone = queue non-empty && accept && !redirect (combinational), popping one entry per idone cycle.
REQ-022 SHALL drive ins = 16'h0 and ins_pc = 0 when the queue is empty.
REQ-023 SHALL on redirect: empty the queue, load fetch PC with {redirect_pc[RV-1:1],1'b0}, and if a request is outstanding without ack this cycle set discard flag.
REQ-024 SHALL, when redirect and mem_ack coincide, drop the returned data and issue the redirect_pc request next cycle.
REQ-025 SHALL, with discard flag set, drop the data of the next mem_ack, clear the flag, then request the redirected PC; redirects while discarding only update fetch PC.
REQ-026 SHALL permit simultaneous push and pop; count unchanged; pointers wrap modulo DEPTH.
REQ-027 SHALL never overflow: request issue is inhibited when count == DEPTH, or count == DEPTH-1 with a non-popping cycle pending ack.
REQ-028 SHALL wrap fetch PC modulo 2^RV without error.

Reset
REQ-029 SHALL on reset asynchronously set: queue empty, pointers 0, discard 0, outstanding 0, fetch PC = RESET_PC with bit 0 cleared; mem_req 0, idone 0, ins 0, ins_pc 0.
REQ-030 SHALL abandon any outstanding request on reset; acks in the first cycle after reset deassertion are ignored; first mem_req asserts the first cycle after reset deassertion.

Structure
REQ-031 SHALL place the fault-substitute instruction constant (16'h0000) in the shared CPU package with the opcode defines.
REQ-032 SHALL implement the queue as one sub-module ifetch_fifo (parameters DEPTH, width 16+RV), the rest in ifetch.

Verification
REQ-033 Reset release, RESET_PC=0x100, ack every cycle after req, accept=1 -> mem_addr 0x80,0x81,...; idone with ins_pc 0x100,0x102,0x104 in order.
REQ-034 accept=0, memory acks immediately -> exactly DEPTH=4 entries filled, mem_req deasserted; accept=1 one cycle -> one pop, one new request.
REQ-035 Request to 0x200 pending, redirect to 0x400, ack 3 cycles later with 0x1234 -> 0x1234 never seen on idone; next mem_addr 0x200; first idone ins_pc 0x400.
REQ-036 redirect same cycle as mem_ack and non-empty queue -> idone 0 that cycle, queue empty next cycle, returned data dropped.
REQ-037 mem_ack with mem_fault=1, mem_rdata=0xFFFF -> idone presents ins 16'h0000 at that PC.
REQ-038 Assert reset mid-request with full queue -> all outputs 0 immediately, restart at RESET_PC.
